// File: rtl/register_loader.sv
// Purpose : debounced push-button loader that writes sw into successive register file words, then reads each back to check it.
// Latency : press pulse in cycle N -> WE in cycle N+1; idle again in N+3 (N+2 when readback checking is compiled out).
// Backpr. : none; presses that arrive while busy are dropped, not queued.
//
// Ports   : clk, reset (sync, active-high); btn raw button; sw data to store;
//           RD register file read data for A; WE/A/WD register file write port;
//           busy high outside IDLE; err readback mismatch flag.
// Config  : define REGISTER_LOADER_VERIFY_EN to enable the VERIFY/ERROR readback states.
module register_loader #(
    parameter int WIDTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int DEBOUNCE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    input  logic [WIDTH-1:0]  sw,
    input  logic [WIDTH-1:0]  RD,
    output logic              WE,
    output logic [ADDR_W-1:0] A,
    output logic [WIDTH-1:0]  WD,
    output logic              busy,
    output logic              err
);

    localparam int                CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
`ifdef REGISTER_LOADER_VERIFY_EN
    localparam logic [1:0] VERIFY = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;
`endif

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              db_q, db_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              press;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
`ifdef REGISTER_LOADER_VERIFY_EN
    logic              err_q, err_d;
`else
    logic              unused_rd;
    assign unused_rd = ^RD;
`endif

    // Synchronizer and debouncer. The press pulse is raised in the same cycle
    // the debounced level is about to rise, so the FSM reacts one edge earlier.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        press   = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                press = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef REGISTER_LOADER_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (press) begin
                    data_d  = sw;
                    state_d = WRITE;
                end
            end
            WRITE: begin
`ifdef REGISTER_LOADER_VERIFY_EN
                state_d = VERIFY;
`else
                addr_d  = addr_q + 1'b1;
                state_d = IDLE;
`endif
            end
`ifdef REGISTER_LOADER_VERIFY_EN
            VERIFY: begin
                if (RD == data_q) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
            ERROR: begin
                // Acknowledge only; the failed word is not rewritten.
                if (press) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef REGISTER_LOADER_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef REGISTER_LOADER_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign WE   = (state_q == WRITE);
    assign A    = addr_q;
    assign WD   = data_q;
    assign busy = (state_q != IDLE);
`ifdef REGISTER_LOADER_VERIFY_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_register_loader.sv
module tb_register_loader;

`ifdef REGISTER_LOADER_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] sw = 4'h0;
    logic [3:0] RD;
    logic       WE;
    logic [1:0] A;
    logic [3:0] WD;
    logic       busy, err;

    logic       btn2 = 1'b0;
    logic [3:0] RD2;
    logic       WE2;
    logic [1:0] A2;
    logic [3:0] WD2;
    logic       busy2, err2;

    logic       corrupt = 1'b0;
    logic [3:0] rf  [4];
    logic [3:0] rf2 [4];

    int n_vec  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int we2_cnt = 0;
    logic [1:0] last_a;
    logic [3:0] last_wd;

    always #5 clk = ~clk;

    register_loader #(.WIDTH(4), .ADDR_W(2), .DEBOUNCE(4)) dut (
        .clk(clk), .reset(reset), .btn(btn), .sw(sw), .RD(RD),
        .WE(WE), .A(A), .WD(WD), .busy(busy), .err(err)
    );

    register_loader #(.WIDTH(4), .ADDR_W(2), .DEBOUNCE(1)) dut1 (
        .clk(clk), .reset(reset), .btn(btn2), .sw(4'hC), .RD(RD2),
        .WE(WE2), .A(A2), .WD(WD2), .busy(busy2), .err(err2)
    );

    // 4x4 register file models; a write coinciding with reset is suppressed.
    assign RD  = (corrupt && WD == 4'h3) ? 4'hF : rf[A];
    assign RD2 = rf2[A2];
    always @(posedge clk) begin
        if (WE && !reset) rf[A] <= WD;
        if (WE2 && !reset) rf2[A2] <= WD2;
    end

    always @(negedge clk) begin
        if (WE === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            last_a  <= A;
            last_wd <= WD;
        end
        if (WE2 === 1'b1) we2_cnt <= we2_cnt + 1;
    end

    typedef struct {
        bit         rst_first;
        logic [3:0] sw;
        logic [1:0] exp_a;
        logic [3:0] exp_wd;
        logic [1:0] exp_next_a;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn   = 1'b0;
        btn2  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, WE}, 0);
        check("rst_a", {30'd0, A}, 0);
        check("rst_wd", {28'd0, WD}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err", {31'd0, err}, 0);
        reset = 1'b0;
    endtask

    // Counts negedges until WE is seen; returns -1 if the budget expires.
    task automatic wait_we(input int max, output int cyc);
        bit found = 1'b0;
        cyc = 0;
        while (!found && cyc < max) begin
            @(negedge clk);
            cyc++;
            if (WE === 1'b1) found = 1'b1;
        end
        if (!found) cyc = -1;
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    vec_t vecs [6];
    int   c;
    int   base;

    initial begin
        // First write then, after reset, five writes wrapping back to address 0.
        vecs[0] = '{1'b0, 4'h9, 2'd0, 4'h9, 2'd1};
        vecs[1] = '{1'b1, 4'h1, 2'd0, 4'h1, 2'd1};
        vecs[2] = '{1'b0, 4'h2, 2'd1, 4'h2, 2'd2};
        vecs[3] = '{1'b0, 4'h3, 2'd2, 4'h3, 2'd3};
        vecs[4] = '{1'b0, 4'h4, 2'd3, 4'h4, 2'd0};
        vecs[5] = '{1'b0, 4'h5, 2'd0, 4'h5, 2'd1};

        do_reset();

        // Clean press: exact latency from btn to WE and from WE to idle.
        sw  = 4'h9;
        btn = 1'b1;
        wait_we(20, c);
        check("lat_btn_to_we", c, 6);
        check("lat_we_a", {30'd0, A}, 0);
        check("lat_we_wd", {28'd0, WD}, 9);
        @(negedge clk);
        check("lat_we_1cyc", {31'd0, WE}, 0);
        check("lat_busy_n2", {31'd0, busy}, {31'd0, VFY});
        @(negedge clk);
        check("lat_busy_n3", {31'd0, busy}, 0);
        check("lat_a_after", {30'd0, A}, 1);
        repeat (8) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("clean_we_count", we_cnt, 1);
        check("clean_err", {31'd0, err}, 0);

        // Table-driven writes; vector 0 repeats the clean-press expectations.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_first) do_reset();
            base = we_cnt;
            press(vecs[i].sw);
            check($sformatf("v%0d_we_count", i), we_cnt - base, 1);
            check($sformatf("v%0d_a", i), {30'd0, last_a}, {30'd0, vecs[i].exp_a});
            check($sformatf("v%0d_wd", i), {28'd0, last_wd}, {28'd0, vecs[i].exp_wd});
            check($sformatf("v%0d_next_a", i), {30'd0, A}, {30'd0, vecs[i].exp_next_a});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 0);
            check($sformatf("v%0d_err", i), {31'd0, err}, 0);
        end
        check("rf0_final", {28'd0, rf[0]}, 5);
        check("rf3_final", {28'd0, rf[3]}, 4);

        // Reset landing on the WRITE cycle, with btn held through release.
        do_reset();
        base = we_cnt;
        sw  = 4'hA;
        btn = 1'b1;
        wait_we(20, c);
        check("rw_we_seen", c, 6);
        reset = 1'b1;
        @(negedge clk);
        check("rw_we", {31'd0, WE}, 0);
        check("rw_a", {30'd0, A}, 0);
        check("rw_busy", {31'd0, busy}, 0);
        check("rw_rf0_kept", {28'd0, rf[0]}, 5);
        reset = 1'b0;
        wait_we(20, c);
        check("held_btn_lat", c, 6);
        check("held_btn_wd", {28'd0, WD}, 4'hA);
        repeat (4) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("held_btn_we_count", we_cnt - base, 2);
        check("held_btn_rf0", {28'd0, rf[0]}, 4'hA);
        check("held_btn_next_a", {30'd0, A}, 1);

        // Bouncing button: no write until the level has been stable long enough.
        do_reset();
        base = we_cnt;
        sw = 4'h6;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            repeat (2) @(negedge clk);
        end
        check("bounce_no_we", we_cnt - base, 0);
        check("bounce_idle", {31'd0, busy}, 0);
        btn = 1'b1;
        wait_we(20, c);
        check("bounce_lat", c, 6);
        repeat (6) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_we_count", we_cnt - base, 1);
        check("bounce_wd", {28'd0, last_wd}, 6);

        // Readback mismatch on a write of 3, then acknowledge with a press.
        do_reset();
        base = we_cnt;
        corrupt = 1'b1;
        press(4'h3);
        check("err_we_count", we_cnt - base, 1);
        check("err_flag", {31'd0, err}, {31'd0, VFY});
        check("err_busy", {31'd0, busy}, {31'd0, VFY});
        check("err_a_held", {30'd0, A}, VFY ? 0 : 1);
        corrupt = 1'b0;
        base = we_cnt;
        press(4'h7);
        check("ack_we_count", we_cnt - base, VFY ? 0 : 1);
        check("ack_err", {31'd0, err}, 0);
        check("ack_busy", {31'd0, busy}, 0);
        check("ack_a", {30'd0, A}, VFY ? 0 : 2);

        // DEBOUNCE=1 instance: second press lands while the first is in flight.
        do_reset();
        @(negedge clk);
        btn2 = 1'b1;
        @(negedge clk);
        btn2 = 1'b0;
        @(negedge clk);
        btn2 = 1'b1;
        repeat (10) @(negedge clk);
        btn2 = 1'b0;
        repeat (10) @(negedge clk);
        check("drop_we_count", we2_cnt, VFY ? 1 : 2);
        check("drop_a", {30'd0, A2}, VFY ? 1 : 2);
        check("drop_rf", {28'd0, rf2[0]}, 4'hC);
        check("drop_err", {31'd0, err2}, 0);
        check("drop_busy", {31'd0, busy2}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_loader.md
REGISTER_LOADER -- requirements
Module: register_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of register file words.
REQ-002 SHALL have parameter ADDR_W, default 2: register file address width.
REQ-003 SHALL have parameter DEBOUNCE, default 16: cycles btn must be stable before acceptance; legal values >= 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port btn, input, 1: raw, asynchronous, bouncing push-button; high = pressed.
REQ-007 SHALL have port sw, input, WIDTH: data value to store.
REQ-008 SHALL have port RD, input, WIDTH: register file combinational read data for address A.
REQ-009 SHALL have port WE, output, 1: register file write enable.
REQ-010 SHALL have port A, output, ADDR_W: register file address.
REQ-011 SHALL have port WD, output, WIDTH: register file write data.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port err, output, 1: readback mismatch flag.

Function
REQ-014 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debouncer: counter increments while synced btn differs from debounced level, clears when equal; on reaching DEBOUNCE-1 the debounced level takes the synced value and the counter clears.
REQ-016 A press event SHALL be a single-cycle pulse on a 0->1 transition of the debounced level; 1->0 generates nothing.
REQ-017 FSM states: IDLE, WRITE, VERIFY, ERROR.
REQ-018 IDLE: WE=0; on press event, sw SHALL be latched into the data register and the next state SHALL be WRITE.
REQ-019 WRITE: WE=1 for exactly one cycle, A=address register, WD=data register; next state VERIFY.
REQ-020 VERIFY: WE=0, A and WD unchanged; RD==data -> address increments, next state IDLE; RD!=data -> err=1, address unchanged, next state ERROR.
REQ-021 ERROR: WE=0, err held high; press event clears err and returns to IDLE without writing; no other exit except reset.
REQ-022 Latency: press pulse on cycle N -> WE high on cycle N+1; busy low again on cycle N+3 on success.
REQ-023 Press events arriving in WRITE or VERIFY SHALL be dropped, not queued.
REQ-024 Address increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-025 A SHALL always equal the address register; WD SHALL always equal the data register.
REQ-026 sw changes after latching SHALL not affect WD until the next press.

Reset
REQ-027 While reset is high at a clock edge: state IDLE, address 0, data 0, WE=0, err=0, busy=0, synchronizer flops 0, debounced level 0, debounce counter 0.
REQ-028 Reset asserted during WRITE SHALL drop WE at that same edge; no partial sequence resumes after reset.
REQ-029 A btn held high through reset release SHALL produce one press event after DEBOUNCE stable cycles.

Configuration
REQ-030 Macro REGISTER_LOADER_VERIFY_EN defined: VERIFY and ERROR states present as above.
REQ-031 Macro undefined: WRITE goes directly to IDLE with address increment, RD ignored, err tied 0, press-to-idle latency N+2.

Verification (WIDTH=4, ADDR_W=2, DEBOUNCE=4, macro defined, RD driven by a 4x4 register model)
REQ-032 sw=4'h9, clean btn press held 10 cycles -> exactly one WE pulse with A=0, WD=9; afterwards A=1, err=0.
REQ-033 btn toggling every 2 cycles for 20 cycles, then held high -> no WE during bounce, exactly one WE after 4 stable cycles.
REQ-034 Five presses with sw=1,2,3,4,5 -> writes to A=0,1,2,3,0; final register 0 holds 5.
REQ-035 Register model forced to return 4'hF on write of 4'h3 -> err=1, state ERROR, A stays; next press -> err=0, no WE, busy=0.
REQ-036 reset asserted on the WRITE cycle -> WE=0, A=0, busy=0 at the next edge; register unchanged.
REQ-037 Second press during WRITE/VERIFY (DEBOUNCE=1) -> ignored; only one WE pulse.
